disp_wr_arbiter: RTL and testbench

Sequences and shares the display text-RAM write port (active-low wen/men, 7-bit address, 4-bit digit) between several writers: telemetry TX monitor, RX monitor, error injector and an auxiliary source.
- Each requester issues single-cycle write flags.
- The block buffers one pending write per requester, filters out-of-range addresses, and applies the display-mode enable mask.
- It grants one write per cycle: a designated high-priority requester wins outright; the remaining requesters share round-robin.
- Its output drives the display block's write inputs directly.

---
 rtl/disp_arb_pkg.sv | 21 ++
 rtl/disp_wr_arbiter_if.sv | 32 +++
 rtl/disp_arb_slot.sv | 66 ++++++
 rtl/disp_wr_arbiter.sv | 114 +++++++++++
 tb/tb_disp_wr_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_arb_pkg.sv
// Shared constants and requester identities for the display write arbiter.
package disp_arb_pkg;

    localparam int ADR_W   = 7;
    localparam int DAT_W   = 4;
    localparam int ADR_MAX = 122;

    // Fixed requester positions on the arbiter's request vectors.
    typedef enum logic [1:0] {
        REQ_TX  = 2'd0,
        REQ_RX  = 2'd1,
        REQ_ERR = 2'd2,
        REQ_AUX = 2'd3
    } req_id_e;

    // True when the address falls inside the visible text RAM.
    function automatic logic addr_in_range(input logic [ADR_W-1:0] addr);
        return (int'(addr) <= ADR_MAX);
    endfunction

endpackage

// File: rtl/disp_wr_arbiter_if.sv
// Bundle of requester inputs and display-RAM write outputs for the arbiter.
interface disp_wr_arbiter_if
    import disp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int P_ADR_W = ADR_W,
    parameter int P_DAT_W = DAT_W
);

    logic [N_REQ-1:0]         i_req_en;
    logic [N_REQ-1:0]         i_req_flag;
    logic [N_REQ*P_ADR_W-1:0] i_req_addr;
    logic [N_REQ*P_DAT_W-1:0] i_req_data;
    logic                     i_clr_ovf;
    logic                     o_disp_wen;
    logic                     o_disp_men;
    logic [P_ADR_W-1:0]       o_disp_adr;
    logic [P_DAT_W-1:0]       o_disp_d;
    logic [N_REQ-1:0]         o_pending;
    logic [N_REQ-1:0]         o_ovf;

    modport slave (
        input  i_req_en, i_req_flag, i_req_addr, i_req_data, i_clr_ovf,
        output o_disp_wen, o_disp_men, o_disp_adr, o_disp_d, o_pending, o_ovf
    );

    modport master (
        output i_req_en, i_req_flag, i_req_addr, i_req_data, i_clr_ovf,
        input  o_disp_wen, o_disp_men, o_disp_adr, o_disp_d, o_pending, o_ovf
    );

endinterface

// File: rtl/disp_arb_slot.sv
// One-deep holding register for a single writer: capture, range filter, overwrite flag.
module disp_arb_slot
    import disp_arb_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_en,
    input  logic             i_flag,
    input  logic [ADR_W-1:0] i_addr,
    input  logic [DAT_W-1:0] i_data,
    input  logic             i_grant,
    input  logic             i_clr_ovf,
    output logic             o_pending,
    output logic             o_ovf,
    output logic [ADR_W-1:0] o_addr,
    output logic [DAT_W-1:0] o_data
);

    logic             pending_q, pending_d;
    logic             ovf_q, ovf_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic [DAT_W-1:0] data_q, data_d;
    logic             capture;

    // Next slot state: a disable drops the slot, a new write replaces it, a grant frees it.
    always_comb begin
        capture   = i_flag & i_en & addr_in_range(i_addr);
        pending_d = pending_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ovf_d     = ovf_q & ~i_clr_ovf;
        if (!i_en) begin
            pending_d = 1'b0;
        end else if (capture) begin
            pending_d = 1'b1;
            addr_d    = i_addr;
            data_d    = i_data;
            if (pending_q && !i_grant) begin
                ovf_d = 1'b1;
            end
        end else if (i_grant) begin
            pending_d = 1'b0;
        end
    end

    // Slot registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign o_pending = pending_q;
    assign o_ovf     = ovf_q;
    assign o_addr    = addr_q;
    assign o_data    = data_q;

endmodule

// File: rtl/disp_wr_arbiter.sv
// Shares the display text-RAM write port: absolute priority for one writer, round-robin for the rest.
module disp_wr_arbiter
    import disp_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int HP_IDX = int'(REQ_ERR)
) (
    input  logic              Clock,
    input  logic              Reset,
    disp_wr_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] ovf;
    logic [N_REQ-1:0] valid;
    logic [N_REQ-1:0] grant_vec;
    logic [ADR_W-1:0] slot_addr [N_REQ];
    logic [DAT_W-1:0] slot_data [N_REQ];

    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    int               cand;

    logic             wen_q, wen_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    for (genvar k = 0; k < N_REQ; k++) begin : g_slot
        disp_arb_slot u_slot (
            .Clock     (Clock),
            .Reset     (Reset),
            .i_en      (bus.i_req_en[k]),
            .i_flag    (bus.i_req_flag[k]),
            .i_addr    (bus.i_req_addr[k*ADR_W +: ADR_W]),
            .i_data    (bus.i_req_data[k*DAT_W +: DAT_W]),
            .i_grant   (grant_vec[k]),
            .i_clr_ovf (bus.i_clr_ovf),
            .o_pending (pend[k]),
            .o_ovf     (ovf[k]),
            .o_addr    (slot_addr[k]),
            .o_data    (slot_data[k])
        );
    end

    assign valid = pend & bus.i_req_en;

    // Pick the winner: the priority writer outright, else the next pending slot after rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        if (valid[HP_IDX]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(HP_IDX);
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                cand = (int'(rr_ptr_q) + i) % N_REQ;
                if (!grant_any && valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = PTR_W'(cand);
                end
            end
        end
    end

    // One-hot grant back to the slots so the winner frees itself.
    always_comb begin
        grant_vec = '0;
        if (grant_any) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // Next output word; address/data hold between writes and only non-priority grants move rr_ptr.
    always_comb begin
        wen_d    = ~grant_any;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            adr_d = slot_addr[grant_idx];
            dat_d = slot_data[grant_idx];
            if (grant_idx != PTR_W'(HP_IDX)) begin
                rr_ptr_d = grant_idx;
            end
        end
    end

    // Output and pointer registers; the pointer starts on the last index so requester 0 goes first.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wen_q    <= 1'b1;
            adr_q    <= '0;
            dat_q    <= '0;
            rr_ptr_q <= PTR_W'(N_REQ - 1);
        end else begin
            wen_q    <= wen_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.o_disp_wen = wen_q;
    assign bus.o_disp_men = wen_q;
    assign bus.o_disp_adr = adr_q;
    assign bus.o_disp_d   = dat_q;
    assign bus.o_pending  = pend;
    assign bus.o_ovf      = ovf;

endmodule

// File: tb/tb_disp_wr_arbiter.sv
// Self-checking bench for disp_wr_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_disp_wr_arbiter;
    import disp_arb_pkg::*;

    localparam int N  = 4;
    localparam int HP = 2;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    disp_wr_arbiter_if #(.N_REQ(N), .P_ADR_W(ADR_W), .P_DAT_W(DAT_W)) bus ();

    disp_wr_arbiter #(.N_REQ(N), .HP_IDX(HP)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic             rst_drive;
    logic [ADR_W-1:0] t_addr [N];
    logic [DAT_W-1:0] t_data [N];
    logic [3:0]       ren;
    int               rr_exp [3] = '{1, 2, 3};

    int m_pend [N];
    int m_addr [N];
    int m_data [N];
    int m_ovf  [N];
    int m_rr;
    int m_wen;
    int m_adr;
    int m_dat;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0;
            m_addr[k] = 0;
            m_data[k] = 0;
            m_ovf[k]  = 0;
        end
        m_rr  = N - 1;
        m_wen = 1;
        m_adr = 0;
        m_dat = 0;
    endtask

    // One clock of the reference: write out the winner, then absorb this cycle's requests.
    task automatic modelStep();
        int grant;
        int a;
        if (Reset === 1'b0) begin
            modelReset();
            return;
        end
        grant = -1;
        if (m_pend[HP] != 0 && bus.i_req_en[HP]) begin
            grant = HP;
        end else begin
            for (int i = 1; i <= N; i++) begin
                if (grant < 0 && m_pend[(m_rr + i) % N] != 0 && bus.i_req_en[(m_rr + i) % N])
                    grant = (m_rr + i) % N;
            end
        end
        if (grant >= 0) begin
            m_wen = 0;
            m_adr = m_addr[grant];
            m_dat = m_data[grant];
            m_pend[grant] = 0;
            if (grant != HP) m_rr = grant;
        end else begin
            m_wen = 1;
        end
        if (bus.i_clr_ovf) begin
            for (int k = 0; k < N; k++) m_ovf[k] = 0;
        end
        for (int k = 0; k < N; k++) begin
            a = int'(bus.i_req_addr[k*ADR_W +: ADR_W]);
            if (!bus.i_req_en[k]) begin
                m_pend[k] = 0;
            end else if (bus.i_req_flag[k] && a <= 122) begin
                if (m_pend[k] != 0) m_ovf[k] = 1;
                m_pend[k] = 1;
                m_addr[k] = a;
                m_data[k] = int'(bus.i_req_data[k*DAT_W +: DAT_W]);
            end
        end
    endtask

    task automatic checkOutput();
        logic [N-1:0] ep;
        logic [N-1:0] eo;
        for (int k = 0; k < N; k++) begin
            ep[k] = (m_pend[k] != 0);
            eo[k] = (m_ovf[k] != 0);
        end
        checkVal("wen",     32'(bus.o_disp_wen), 32'(m_wen));
        checkVal("men",     32'(bus.o_disp_men), 32'(m_wen));
        checkVal("adr",     32'(bus.o_disp_adr), 32'(m_adr));
        checkVal("d",       32'(bus.o_disp_d),   32'(m_dat));
        checkVal("pending", 32'(bus.o_pending),  32'(ep));
        checkVal("ovf",     32'(bus.o_ovf),      32'(eo));
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [3:0] flag, input logic clr);
        @(negedge Clock);
        Reset          = rst_drive;
        bus.i_req_en   = en;
        bus.i_req_flag = flag;
        bus.i_clr_ovf  = clr;
        for (int k = 0; k < N; k++) begin
            bus.i_req_addr[k*ADR_W +: ADR_W] = t_addr[k];
            bus.i_req_data[k*DAT_W +: DAT_W] = t_data[k];
        end
        @(posedge Clock);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus(4'hF, 4'h0, 1'b0);
    endtask

    initial begin
        rst_drive      = 1'b0;
        bus.i_req_en   = '0;
        bus.i_req_flag = '0;
        bus.i_req_addr = '0;
        bus.i_req_data = '0;
        bus.i_clr_ovf  = 1'b0;
        for (int k = 0; k < N; k++) begin
            t_addr[k] = '0;
            t_data[k] = '0;
        end
        modelReset();

        // reset values
        idle();
        idle();
        checkVal("rst_wen", 32'(bus.o_disp_wen), 32'd1);
        checkVal("rst_men", 32'(bus.o_disp_men), 32'd1);
        checkVal("rst_pending", 32'(bus.o_pending), 32'd0);
        rst_drive = 1'b1;
        idle();

        // round-robin, twice: same order both times
        for (int rep = 0; rep < 2; rep++) begin
            t_addr[0] = 7'd1; t_addr[1] = 7'd2; t_addr[3] = 7'd3;
            t_data[0] = 4'd1; t_data[1] = 4'd2; t_data[3] = 4'd3;
            applyStimulus(4'hF, 4'b1011, 1'b0);
            checkVal("rr_pending", 32'(bus.o_pending), 32'hB);
            for (int i = 0; i < 3; i++) begin
                idle();
                checkVal("rr_wen", 32'(bus.o_disp_wen), 32'd0);
                checkVal("rr_adr", 32'(bus.o_disp_adr), 32'(rr_exp[i]));
            end
            idle();
            checkVal("rr_done_wen", 32'(bus.o_disp_wen), 32'd1);
        end

        // single write, two-cycle latency
        t_addr[0] = 7'd5; t_data[0] = 4'd7;
        applyStimulus(4'hF, 4'b0001, 1'b0);
        checkVal("single_pending", 32'(bus.o_pending), 32'h1);
        checkVal("single_wen_t1", 32'(bus.o_disp_wen), 32'd1);
        idle();
        checkVal("single_wen_t2", 32'(bus.o_disp_wen), 32'd0);
        checkVal("single_adr", 32'(bus.o_disp_adr), 32'd5);
        checkVal("single_d", 32'(bus.o_disp_d), 32'd7);
        idle();
        checkVal("single_wen_t3", 32'(bus.o_disp_wen), 32'd1);

        // priority writer hogs the port
        t_addr[0] = 7'd10; t_data[0] = 4'd1;
        t_addr[2] = 7'd20; t_data[2] = 4'd2;
        applyStimulus(4'hF, 4'b0101, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'hF, 4'b0100, 1'b0);
            checkVal("prio_adr", 32'(bus.o_disp_adr), 32'd20);
        end
        idle();
        checkVal("prio_last_hp", 32'(bus.o_disp_adr), 32'd20);
        idle();
        checkVal("prio_req0_adr", 32'(bus.o_disp_adr), 32'd10);
        checkVal("prio_no_ovf", 32'(bus.o_ovf), 32'd0);
        idle();

        // range filter and enable mask
        t_addr[1] = 7'd123;
        applyStimulus(4'hF, 4'b0010, 1'b0);
        checkVal("range_pending", 32'(bus.o_pending), 32'd0);
        idle();
        checkVal("range_wen", 32'(bus.o_disp_wen), 32'd1);
        t_addr[1] = 7'd122;
        applyStimulus(4'b1101, 4'b0010, 1'b0);
        checkVal("mask_pending", 32'(bus.o_pending), 32'd0);
        idle();
        checkVal("mask_wen", 32'(bus.o_disp_wen), 32'd1);
        t_addr[1] = 7'd50; t_addr[2] = 7'd60;
        applyStimulus(4'hF, 4'b0110, 1'b0);
        applyStimulus(4'b1101, 4'b0100, 1'b0);
        checkVal("drop_pending1", 32'(bus.o_pending[1]), 32'd0);
        idle();
        idle();
        checkVal("drop_wen", 32'(bus.o_disp_wen), 32'd1);
        checkVal("drop_adr", 32'(bus.o_disp_adr), 32'd60);

        // overwrite while blocked sets ovf, write carries the newer data
        t_addr[3] = 7'd70; t_data[3] = 4'd5; t_data[2] = 4'd2;
        applyStimulus(4'hF, 4'b1100, 1'b0);
        t_data[3] = 4'd9;
        applyStimulus(4'hF, 4'b1100, 1'b0);
        checkVal("ovf_set", 32'(bus.o_ovf), 32'h8);
        idle();
        idle();
        checkVal("ovf_adr", 32'(bus.o_disp_adr), 32'd70);
        checkVal("ovf_d", 32'(bus.o_disp_d), 32'd9);
        checkVal("ovf_held", 32'(bus.o_ovf), 32'h8);
        applyStimulus(4'hF, 4'h0, 1'b1);
        checkVal("ovf_clr", 32'(bus.o_ovf), 32'd0);

        // asynchronous reset mid-stream
        t_addr[0] = 7'd11; t_addr[1] = 7'd12; t_addr[3] = 7'd13;
        applyStimulus(4'hF, 4'b1011, 1'b0);
        idle();
        checkVal("mid_wen_low", 32'(bus.o_disp_wen), 32'd0);
        #1;
        Reset          = 1'b0;
        bus.i_req_flag = '0;
        #1;
        modelReset();
        checkVal("arst_wen", 32'(bus.o_disp_wen), 32'd1);
        checkVal("arst_men", 32'(bus.o_disp_men), 32'd1);
        checkVal("arst_adr", 32'(bus.o_disp_adr), 32'd0);
        checkVal("arst_d", 32'(bus.o_disp_d), 32'd0);
        checkVal("arst_pending", 32'(bus.o_pending), 32'd0);
        rst_drive = 1'b0;
        idle();
        rst_drive = 1'b1;
        idle();
        t_addr[0] = 7'd21; t_addr[3] = 7'd23;
        applyStimulus(4'hF, 4'b1001, 1'b0);
        idle();
        checkVal("post_rst_first", 32'(bus.o_disp_adr), 32'd21);
        idle();
        checkVal("post_rst_second", 32'(bus.o_disp_adr), 32'd23);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                t_addr[k] = 7'($urandom_range(0, 127));
                t_data[k] = 4'($urandom);
                ren[k]    = ($urandom_range(0, 9) != 0);
            end
            applyStimulus(ren, 4'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
